// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared state encoding and address constants for the two-port memory arbiter.
package memory_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_e;
  localparam logic [21:0] PARK_ADDR_DEFAULT = 22'h000000;
  localparam logic [21:0] CONSOLE_ADDR = 22'h3FFFFF;
endpackage

// File: rtl/memory_arbiter_rr2.sv
// arb_rr2: two-way round-robin tie-break; a lone request wins, on a tie the port not granted last wins.
module arb_rr2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);
  assign gnt_o[0] = req_i[0] & (~req_i[1] | last_i);
  assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_i);
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-ported memory between two request/ack ports, 3 cycles per access.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter logic [21:0] PARK_ADDR = PARK_ADDR_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [21:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_wmask,
  output logic        p0_ack,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [21:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_wmask,
  output logic        p1_ack,
  output logic [31:0] p1_rdata,
  output logic [21:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_wlo,
  output logic        mem_olo
);
  state_e      state_q, state_d;
  logic        win_q, win_d;
  logic        we_q, we_d;
  logic [21:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [1:0]  ack_q;
  logic [31:0] rdata0_q, rdata1_q;
  logic [21:0] mem_address_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_wmask_q;
  logic        mem_wlo_q, mem_olo_q;
  logic [1:0]  req, gnt;
  logic        take;
  // A port being acked this cycle still holds req; masking it stops a regrant.
  assign req = {p1_req & ~ack_q[1], p0_req & ~ack_q[0]};
  arb_rr2 u_rr (.req_i(req), .last_i(win_q), .gnt_o(gnt));
  always_comb begin
    take    = (state_q == IDLE) && (|gnt);
    state_d = state_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    if (take) begin
      state_d = ISSUE;
      win_d   = gnt[1];
      we_d    = gnt[1] ? p1_we : p0_we;
      addr_d  = gnt[1] ? p1_addr : p0_addr;
      wdata_d = gnt[1] ? p1_wdata : p0_wdata;
      wmask_d = gnt[1] ? p1_wmask : p0_wmask;
    end else if (state_q != IDLE) begin
      state_d = (state_q == ISSUE) ? DATA : IDLE;
    end
  end
  // Memory-side outputs are registered from the next state so they line up with ISSUE/DATA.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      win_q         <= 1'b1;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wmask_q       <= 4'hF;
      ack_q         <= 2'b00;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      mem_address_q <= PARK_ADDR;
      mem_wdata_q   <= '0;
      mem_wmask_q   <= 4'hF;
      mem_wlo_q     <= 1'b1;
      mem_olo_q     <= 1'b1;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wmask_q       <= wmask_d;
      ack_q         <= (state_q == DATA) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
      if (state_q == DATA && !we_q && !win_q) rdata0_q <= mem_rdata;
      if (state_q == DATA && !we_q && win_q) rdata1_q <= mem_rdata;
      mem_address_q <= (state_d == ISSUE) ? addr_d : PARK_ADDR;
      mem_wdata_q   <= (state_d == DATA && we_d) ? wdata_d : 32'h0;
      mem_wmask_q   <= (state_d == DATA && we_d) ? wmask_d : 4'hF;
      mem_wlo_q     <= !(state_d == ISSUE && we_d);
      mem_olo_q     <= !(state_d == DATA && !we_d);
    end
  end
  assign p0_ack      = ack_q[0];
  assign p1_ack      = ack_q[1];
  assign p0_rdata    = rdata0_q;
  assign p1_rdata    = rdata1_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wmask   = mem_wmask_q;
  assign mem_wlo     = mem_wlo_q;
  assign mem_olo     = mem_olo_q;
endmodule
